// File: rtl/guess_checker_pkg.sv
// Shared widths, letter codes and FSM state type for the guess checker.
package guess_checker_pkg;
    localparam int CHAR_W  = 5;
    localparam int ADDR_W  = 5;
    localparam int MAX_LEN = 31;

    localparam logic [CHAR_W-1:0] CH_A = 5'd1;
    localparam logic [CHAR_W-1:0] CH_Z = 5'd26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic [ADDR_W-1:0] popcount31(input logic [30:0] v);
        logic [ADDR_W-1:0] c;
        c = '0;
        for (int i = 0; i < 31; i++) begin
            c = c + {{(ADDR_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction
endpackage

// File: rtl/guess_checker_if.sv
// Guess offer, RAM read port and result bundle between player-2 logic and the checker.
interface guess_checker_if;
    import guess_checker_pkg::*;

    logic              new_word;
    logic [ADDR_W-1:0] wordlength;
    logic              guess_valid;
    logic [CHAR_W-1:0] guess_char;
    logic              guess_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [CHAR_W-1:0] ram_q;
    logic              done;
    logic              hit;
    logic              miss;
    logic              repeat_guess;
    logic              reject;
    logic [ADDR_W-1:0] new_hits;
    logic [31:0]       revealed;
    logic [ADDR_W-1:0] remaining;
    logic              solved;

    modport slave (
        input  new_word, wordlength, guess_valid, guess_char, ram_q,
        output guess_ready, ram_addr, done, hit, miss, repeat_guess, reject,
               new_hits, revealed, remaining, solved
    );

    modport master (
        output new_word, wordlength, guess_valid, guess_char, ram_q,
        input  guess_ready, ram_addr, done, hit, miss, repeat_guess, reject,
               new_hits, revealed, remaining, solved
    );
endinterface

// File: rtl/guess_history.sv
// Used-letter vector for the GUESS_HISTORY_EN build; clear has priority over set.
module guess_history
    import guess_checker_pkg::*;
(
    input  logic              clk,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              set_i,
    input  logic [CHAR_W-1:0] char_i,
    output logic              used_o
);
    logic [25:0]       used_q;
    logic [CHAR_W-1:0] idx;
    logic              in_range;

    assign idx      = char_i - CH_A;
    assign in_range = (char_i >= CH_A) && (char_i <= CH_Z);
    assign used_o   = in_range ? used_q[idx] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst_i || clr_i) begin
            used_q <= '0;
        end else if (set_i && in_range) begin
            used_q[idx] <= 1'b1;
        end
    end
endmodule

// File: rtl/guess_checker.sv
// Scans the stored word for a guessed letter and tracks revealed positions.
// States: IDLE accept | SCAN read 1..L | FLUSH last compare | DONE result pulse. Macro: GUESS_HISTORY_EN.
module guess_checker
    import guess_checker_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    guess_checker_if.slave bus
);
    state_t            state_q;
    logic [ADDR_W-1:0] len_q, addr_q, new_hits_q;
    logic [CHAR_W-1:0] guess_q;
    logic [31:1]       revealed_q;
    logic              done_q, hit_q, miss_q, rep_q, rej_q;

    logic              ready, accept, valid_code, used;
    logic              cmp_en, match;
    logic [ADDR_W-1:0] cmp_pos, hits_nxt, remaining;
    logic              solved;

    assign remaining  = len_q - popcount31(revealed_q);
    assign solved     = (remaining == '0) && (len_q != '0);
    assign ready      = (state_q == ST_IDLE) && !solved;
    assign accept     = bus.guess_valid && ready && !bus.new_word;
    assign valid_code = (bus.guess_char >= CH_A) && (bus.guess_char <= CH_Z);

`ifdef GUESS_HISTORY_EN
    guess_history u_history (
        .clk    (clk),
        .rst_i  (resetn),
        .clr_i  (bus.new_word),
        .set_i  (accept),
        .char_i (bus.guess_char),
        .used_o (used)
    );
`else
    assign used = 1'b0;
`endif

    // RAM data lags the address by one cycle, so SCAN compares position addr-1
    always_comb begin
        cmp_en  = 1'b0;
        cmp_pos = '0;
        if (state_q == ST_SCAN) begin
            cmp_en  = (addr_q >= 5'd2);
            cmp_pos = addr_q - 5'd1;
        end else if (state_q == ST_FLUSH) begin
            cmp_en  = (len_q != '0);
            cmp_pos = len_q;
        end
        match    = cmp_en && (bus.ram_q == guess_q) && !revealed_q[cmp_pos];
        hits_nxt = new_hits_q + {{(ADDR_W-1){1'b0}}, match};
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            guess_q    <= '0;
            new_hits_q <= '0;
            revealed_q <= '0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            rep_q      <= 1'b0;
            rej_q      <= 1'b0;
        end else if (bus.new_word) begin
            state_q    <= ST_IDLE;
            len_q      <= bus.wordlength;
            addr_q     <= '0;
            new_hits_q <= '0;
            revealed_q <= '0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            rep_q      <= 1'b0;
            rej_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            rep_q  <= 1'b0;
            rej_q  <= 1'b0;
            if (match) begin
                revealed_q[cmp_pos] <= 1'b1;
                new_hits_q          <= hits_nxt;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        guess_q    <= bus.guess_char;
                        new_hits_q <= '0;
                        if (!valid_code) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            rej_q   <= 1'b1;
                        end else if (used) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            rep_q   <= 1'b1;
                        end else if (len_q == '0) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            state_q <= ST_SCAN;
                            addr_q  <= 5'd1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (addr_q == len_q) begin
                        state_q <= ST_FLUSH;
                        addr_q  <= '0;
                    end else begin
                        addr_q <= addr_q + 5'd1;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    hit_q   <= (hits_nxt != '0);
                    miss_q  <= (hits_nxt == '0);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.guess_ready  = ready;
    assign bus.ram_addr     = addr_q;
    assign bus.done         = done_q;
    assign bus.hit          = hit_q;
    assign bus.miss         = miss_q;
    assign bus.repeat_guess = rep_q;
    assign bus.reject       = rej_q;
    assign bus.new_hits     = new_hits_q;
    assign bus.revealed     = {revealed_q, 1'b0};
    assign bus.remaining    = remaining;
    assign bus.solved       = solved;
endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker: a behavioural model pushes expected results, done pops and compares.
module tb_guess_checker;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   failures = 0;

`ifdef GUESS_HISTORY_EN
    localparam bit HIST_EN = 1'b1;
`else
    localparam bit HIST_EN = 1'b0;
`endif

    typedef struct {
        int          lat;
        logic        hit, miss, rep, rej;
        logic [4:0]  nh;
        logic [31:0] rev;
        logic [4:0]  rem;
    } exp_t;

    exp_t        sb[$];
    logic [4:0]  mem[32];
    int          m_len = 0;
    logic [31:0] m_mask = '0;
    logic [25:0] m_used = '0;

    guess_checker_if bus();

    guess_checker dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_remaining();
        int n = 0;
        for (int p = 1; p < 32; p++) if (m_mask[p]) n++;
        return m_len - n;
    endfunction

    function automatic bit m_solved();
        return (m_len != 0) && (m_remaining() == 0);
    endfunction

    task automatic model_new_word(input int len);
        m_len  = len;
        m_mask = '0;
        m_used = '0;
    endtask

    task automatic model_guess(input logic [4:0] c, output exp_t e);
        int idx;
        e = '{default: 0};
        idx = int'(c) - 1;
        if (c < 5'd1 || c > 5'd26) begin
            e.rej = 1'b1;
            e.lat = 1;
        end else if (HIST_EN && m_used[idx]) begin
            e.rep = 1'b1;
            e.lat = 1;
        end else begin
            e.lat = m_len + 2;
            for (int p = 1; p <= m_len; p++) begin
                if (mem[p] == c && !m_mask[p]) begin
                    m_mask[p] = 1'b1;
                    e.nh = e.nh + 5'd1;
                end
            end
            e.hit  = (e.nh != 0);
            e.miss = (e.nh == 0);
        end
        if (HIST_EN && !e.rej) m_used[idx] = 1'b1;
        e.rev = m_mask;
        e.rem = 5'(m_remaining());
    endtask

    task automatic pulse_new_word(input int len);
        @(negedge clk);
        bus.new_word   = 1'b1;
        bus.wordlength = 5'(len);
        @(posedge clk);
        #1 bus.new_word = 1'b0;
        model_new_word(len);
    endtask

    task automatic do_guess(input logic [4:0] c);
        exp_t e;
        int   cyc;
        bit   seen;
        model_guess(c, e);
        sb.push_back(e);
        @(negedge clk);
        chk("ready_idle", bus.guess_ready, 1);
        bus.guess_valid = 1'b1;
        bus.guess_char  = c;
        @(posedge clk);
        #1 bus.guess_valid = 1'b0;
        cyc  = 1;
        seen = 0;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            chk("ready_busy", bus.guess_ready, 0);
            if (bus.done) seen = 1;
            else cyc++;
        end
        chk("done_seen", 32'(seen), 1);
        e = sb.pop_front();
        if (seen) begin
            chk("latency", cyc, e.lat);
            chk("hit", bus.hit, e.hit);
            chk("miss", bus.miss, e.miss);
            chk("repeat", bus.repeat_guess, e.rep);
            chk("reject", bus.reject, e.rej);
            chk("new_hits", bus.new_hits, e.nh);
            chk("revealed", bus.revealed, e.rev);
            chk("remaining", bus.remaining, e.rem);
        end
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("miss_pulse", bus.miss, 0);
        chk("ready_after", bus.guess_ready, !m_solved());
    endtask

    // Accept a guess and stop driving at the start of scan cycle 3.
    task automatic start_scan_to_cycle3(input logic [4:0] c);
        @(negedge clk);
        bus.guess_valid = 1'b1;
        bus.guess_char  = c;
        @(posedge clk);
        #1 bus.guess_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem = '{default: 5'd0};
        mem[1] = 5'd8; mem[2] = 5'd5; mem[3] = 5'd12; mem[4] = 5'd12; mem[5] = 5'd15;
        bus.new_word = 1'b0; bus.wordlength = '0;
        bus.guess_valid = 1'b0; bus.guess_char = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_revealed", bus.revealed, 0);
        chk("rst_remaining", bus.remaining, 0);
        chk("rst_solved", bus.solved, 0);
        chk("rst_new_hits", bus.new_hits, 0);

        pulse_new_word(5);
        @(negedge clk);
        chk("nw_remaining", bus.remaining, 5);
        do_guess(5'd12);
        chk("hello_L_rev", bus.revealed, 32'h18);
        do_guess(5'd26);
        do_guess(5'd0);
        chk("reject_mask", bus.revealed, 32'h18);
        do_guess(5'd27);
        do_guess(5'd12);
        do_guess(5'd8);
        do_guess(5'd5);
        do_guess(5'd15);
        chk("solved_rev", bus.revealed, 32'h3E);
        chk("solved_rem", bus.remaining, 0);
        chk("solved", bus.solved, 1);
        chk("solved_ready", bus.guess_ready, 0);

        bus.guess_valid = 1'b1;
        bus.guess_char  = 5'd3;
        repeat (4) begin
            @(negedge clk);
            chk("solved_no_done", bus.done, 0);
        end
        bus.guess_valid = 1'b0;
        chk("solved_rev_hold", bus.revealed, 32'h3E);

        pulse_new_word(5);
        start_scan_to_cycle3(5'd12);
        bus.new_word   = 1'b1;
        bus.wordlength = 5'd4;
        @(posedge clk);
        #1 bus.new_word = 1'b0;
        model_new_word(4);
        @(negedge clk);
        chk("abort_revealed", bus.revealed, 0);
        chk("abort_remaining", bus.remaining, 4);
        chk("abort_new_hits", bus.new_hits, 0);
        chk("abort_ready", bus.guess_ready, 1);
        repeat (10) begin
            chk("abort_no_done", bus.done, 0);
            @(negedge clk);
        end

        do_guess(5'd12);
        pulse_new_word(0);
        do_guess(5'd3);

        pulse_new_word(4);
        start_scan_to_cycle3(5'd8);
        resetn = 1'b1;
        @(posedge clk);
        #1 resetn = 1'b0;
        model_new_word(0);
        @(negedge clk);
        chk("mid_rst_ram_addr", bus.ram_addr, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_revealed", bus.revealed, 0);
        chk("mid_rst_remaining", bus.remaining, 0);
        chk("mid_rst_new_hits", bus.new_hits, 0);
        chk("mid_rst_ready", bus.guess_ready, 1);
        repeat (8) begin
            @(negedge clk);
            chk("mid_rst_no_done", bus.done, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/guess_checker.md
# guess_checker

Reader-side partner to the word-entry path. Player 1's word sits in the 32×5 character RAM at addresses 1..wordlength. This block takes a guessed character from player 2 and scans that RAM through its read port. It compares every stored position against the guess and maintains the revealed-position mask and remaining-letter count. It reports hit or miss per guess: the miss pulse drives the hangman part counter, and `solved` drives player-2 scoring.

## Interface
- `MAX_LEN`, 31: largest legal wordlength; positions 1..MAX_LEN, address 0 unused.
- `clk` in 1: single clock.
- `resetn` in 1: synchronous, active-high reset (asserted = 1).
- `new_word` in 1: one-cycle pulse; latch `wordlength`, clear mask and history, abort any scan.
- `wordlength` in 5: word length, sampled on `new_word`.
- `guess_valid` in 1, `guess_char` in 5: guess offer; codes 1..26 = A..Z.
- `guess_ready` out 1: high in IDLE when not `solved`; transfer on valid & ready.
- `ram_addr` out 5: RAM read address.
- `ram_q` in 5: RAM data, one-cycle read latency.
- `done` out 1: one-cycle pulse, result valid.
- `hit` / `miss` / `repeat_guess` / `reject` out 1: qualified by `done`; miss is a pulse.
- `new_hits` out 5: positions newly revealed by this guess.
- `revealed` out 32: bit i = position i revealed; bit 0 always 0.
- `remaining` out 5: wordlength − popcount(revealed).
- `solved` out 1: remaining == 0 and wordlength != 0.

## Operation
- States: IDLE → SCAN → FLUSH → DONE → IDLE.
- **IDLE:** accept a guess and register it. Invalid codes (0, 27..31) go straight to DONE with `reject`=1; mask and flags are otherwise unchanged.
- **SCAN:** present `ram_addr` = 1..L, one per cycle. Compare `ram_q` for address k−1 in the same cycle. On a match with bit unrevealed: set bit, increment new_hits.
- **FLUSH:** compares the final address.
- **DONE:** pulse `done`.
  - hit = new_hits != 0; miss = !hit & !reject & !repeat_guess.
  - `remaining` updates with the mask in the same cycle.
- **L = 0:** SCAN is skipped; the guess is a miss.
- **Guess after solved:** not accepted (ready low).
- **`new_word`** (any state, wins over guess acceptance): next cycle IDLE, mask 0, remaining = wordlength, new_hits 0, no `done`.
- Repeated letter without the filter: rescanned, new_hits = 0, reported as a miss.
- **Reset values:** IDLE, ram_addr 0, all flags 0, new_hits 0, revealed 0, remaining 0, solved 0, wordlength register 0.

## Timing
- Acceptance at cycle 0. ram_addr = k at cycle k. `done` at cycle L+2. Invalid or filtered guess: `done` at cycle 1.
- `guess_ready` is low from cycle 1 through the `done` cycle and returns high the cycle after.
- `reset` mid-scan: all reset values on the next cycle; no `done`.

## Configuration
- `GUESS_HISTORY_EN` defined:
  - A 26-bit used-letter vector is kept, cleared by `new_word`/reset.
  - A guess of a used letter skips the scan: `done` at cycle 1, `repeat_guess`=1, miss=0, hit=0.
- `GUESS_HISTORY_EN` undefined: no history; `repeat_guess` tied 0.

## Structure
- Shared package:
  - `CHAR_W`=5, `ADDR_W`=5.
  - Letter code constants `CH_A`=1 .. `CH_Z`=26.
  - FSM state enum.
- Sub-module `guess_history`: used-letter vector; set/clear/query ports; instantiated only under the macro.
- The RAM is external.

## Test plan
- new_word L=5 with RAM "HELLO" (8,5,12,12,15); guess 12 → done at cycle 7, hit=1, new_hits=2, revealed=0x18, remaining=3.
- Then guess 26 → done at cycle 7, miss pulse=1, revealed=0x18, remaining=3.
- Guess 12 again → with macro: done at cycle 1, repeat_guess=1, miss=0. Without macro: done at cycle 7, new_hits=0, miss=1.
- Guess 8, 5, 15 → revealed=0x3E, remaining=0, solved=1, guess_ready=0; a further guess_valid is ignored.
- guess_char 0 → done at cycle 1, reject=1, miss=0, mask unchanged.
- new_word (L=4) at cycle 3 of a scan → no done, revealed=0, remaining=4. Repeat the scan with resetn at cycle 3 → next cycle all outputs at reset values.
